// File: rtl/uart_tx_serializer_if.sv
// Handshake bundle between the system-side requester and the UART TX serializer.
// The requester drives word, valid and parity settings; the serializer returns the line and busy.
interface uart_tx_serializer_if #(
  parameter int DATA_WD = 8
);
  logic [DATA_WD-1:0] i_p_data;
  logic               i_data_valid;
  logic               i_par_en;
  logic               i_par_typ;
  logic               o_tx_out;
  logic               o_busy;

  modport master (
    output i_p_data,
    output i_data_valid,
    output i_par_en,
    output i_par_typ,
    input  o_tx_out,
    input  o_busy
  );

  modport slave (
    input  i_p_data,
    input  i_data_valid,
    input  i_par_en,
    input  i_par_typ,
    output o_tx_out,
    output o_busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer, one bit per i_clk: start, data LSB-first, optional parity, stop.
// Define UART_TX_STOP2_EN to send two stop bits instead of one.
//
// state    | meaning
// S_IDLE   | line high, not busy, waiting for i_data_valid
// S_START  | start bit (0) on the line
// S_DATA   | data bit r_data[r_cnt] on the line
// S_PARITY | parity of the latched word on the line
// S_STOP   | stop bit(s) on the line
module uart_tx_serializer #(
  parameter int DATA_WD = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  uart_tx_serializer_if.slave   io_bus
);

  localparam int CNT_WD = $clog2(DATA_WD);
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(DATA_WD - 1);
  localparam logic [CNT_WD-1:0] CNT_ONE  = CNT_WD'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             r_state;
  logic [CNT_WD-1:0]  r_cnt;
  logic [DATA_WD-1:0] r_data;
  logic               r_par_en;
  logic               r_par_typ;
  logic               r_tx_out;
  logic               r_busy;

  logic [CNT_WD-1:0]  w_cnt_nxt;
  logic               w_parity;

  assign w_cnt_nxt = r_cnt + CNT_ONE;
  // Parity comes from the shadow word so mid-frame input changes cannot leak in.
  assign w_parity  = (^r_data) ^ r_par_typ;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_tx_out  <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.i_data_valid) begin
            r_data    <= io_bus.i_p_data;
            r_par_en  <= io_bus.i_par_en;
            r_par_typ <= io_bus.i_par_typ;
            r_state   <= S_START;
            r_tx_out  <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_START: begin
          r_state  <= S_DATA;
          r_cnt    <= '0;
          r_tx_out <= r_data[0];
        end
        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (r_par_en) begin
              r_state  <= S_PARITY;
              r_tx_out <= w_parity;
            end else begin
              r_state  <= S_STOP;
              r_tx_out <= 1'b1;
            end
          end else begin
            r_cnt    <= w_cnt_nxt;
            r_tx_out <= r_data[w_cnt_nxt];
          end
        end
        S_PARITY: begin
          r_state  <= S_STOP;
          r_tx_out <= 1'b1;
        end
        S_STOP: begin
`ifdef UART_TX_STOP2_EN
          // r_cnt counts the stop cycles already sent
          if (r_cnt == '0) begin
            r_cnt    <= CNT_ONE;
            r_tx_out <= 1'b1;
          end else begin
            r_cnt    <= '0;
            r_state  <= S_IDLE;
            r_tx_out <= 1'b1;
            r_busy   <= 1'b0;
          end
`else
          r_state  <= S_IDLE;
          r_tx_out <= 1'b1;
          r_busy   <= 1'b0;
`endif
        end
        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_tx_out <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.o_tx_out = r_tx_out;
  assign io_bus.o_busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frames, parity, back-to-back, mid-frame changes, reset.
// Honours UART_TX_STOP2_EN so frame lengths follow the build.
module tb_uart_tx_serializer;
  localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
  localparam int STOP_X = 1;
`else
  localparam int STOP_X = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  uart_tx_serializer_if #(.DATA_WD(DW)) bus_if ();

  uart_tx_serializer #(.DATA_WD(DW)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus_if.slave)
  );

  // Line value at sample i after the accepting edge; beyond the frame the line idles high.
  function automatic logic frame_bit(input logic [7:0] d, input logic pe, input logic pbit, input int i);
    if (i == 0) return 1'b0;
    if (i >= 1 && i <= 8) return d[i-1];
    if (pe && i == 9) return pbit;
    return 1'b1;
  endfunction

  task automatic test_reset();
    bus_if.i_p_data     = 8'h00;
    bus_if.i_par_en     = 1'b0;
    bus_if.i_par_typ    = 1'b0;
    bus_if.i_data_valid = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_if.o_tx_out !== 1'b1) begin
      errs++; $display("FAIL reset_tx: got %b want 1", bus_if.o_tx_out);
    end
    checks++;
    if (bus_if.o_busy !== 1'b0) begin
      errs++; $display("FAIL reset_busy: got %b want 0", bus_if.o_busy);
    end
    bus_if.i_data_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int len;
    len = 10 + STOP_X;
    bus_if.i_p_data     = 8'hA5;
    bus_if.i_par_en     = 1'b0;
    bus_if.i_data_valid = 1'b1;
    for (int i = 0; i < len + 2; i++) begin
      @(negedge clk);
      bus_if.i_data_valid = 1'b0;
      checks++;
      if (bus_if.o_tx_out !== frame_bit(8'hA5, 1'b0, 1'b0, i)) begin
        errs++; $display("FAIL basic_tx[%0d]: got %b want %b", i, bus_if.o_tx_out, frame_bit(8'hA5, 1'b0, 1'b0, i));
      end
      checks++;
      if (bus_if.o_busy !== (i < len)) begin
        errs++; $display("FAIL basic_busy[%0d]: got %b want %b", i, bus_if.o_busy, (i < len));
      end
    end
  endtask

  task automatic test_parity();
    int len;
    len = 11 + STOP_X;
    for (int k = 0; k < 2; k++) begin
      // 0xA5 has four ones: even parity bit 0, odd parity bit 1
      bus_if.i_p_data     = 8'hA5;
      bus_if.i_par_en     = 1'b1;
      bus_if.i_par_typ    = k[0];
      bus_if.i_data_valid = 1'b1;
      for (int i = 0; i < len + 2; i++) begin
        @(negedge clk);
        bus_if.i_data_valid = 1'b0;
        checks++;
        if (bus_if.o_tx_out !== frame_bit(8'hA5, 1'b1, k[0], i)) begin
          errs++; $display("FAIL parity%0d_tx[%0d]: got %b want %b", k, i, bus_if.o_tx_out, frame_bit(8'hA5, 1'b1, k[0], i));
        end
        checks++;
        if (bus_if.o_busy !== (i < len)) begin
          errs++; $display("FAIL parity%0d_busy[%0d]: got %b want %b", k, i, bus_if.o_busy, (i < len));
        end
      end
    end
    bus_if.i_par_en  = 1'b0;
    bus_if.i_par_typ = 1'b0;
  endtask

  task automatic test_back_to_back();
    int   len;
    logic exp_tx;
    logic exp_busy;
    len = 10 + STOP_X;
    bus_if.i_p_data     = 8'h00;
    bus_if.i_data_valid = 1'b1;
    for (int i = 0; i < 2 * len + 4; i++) begin
      @(negedge clk);
      if (i < len) begin
        exp_tx = frame_bit(8'h00, 1'b0, 1'b0, i);  exp_busy = 1'b1;
      end else if (i == len) begin
        exp_tx = 1'b1;                             exp_busy = 1'b0;
      end else if (i <= 2 * len) begin
        exp_tx = frame_bit(8'hFF, 1'b0, 1'b0, i - len - 1); exp_busy = 1'b1;
      end else begin
        exp_tx = 1'b1;                             exp_busy = 1'b0;
      end
      checks++;
      if (bus_if.o_tx_out !== exp_tx) begin
        errs++; $display("FAIL b2b_tx[%0d]: got %b want %b", i, bus_if.o_tx_out, exp_tx);
      end
      checks++;
      if (bus_if.o_busy !== exp_busy) begin
        errs++; $display("FAIL b2b_busy[%0d]: got %b want %b", i, bus_if.o_busy, exp_busy);
      end
      if (i == 0) bus_if.i_p_data = 8'hFF;
      if (i == len + 1) bus_if.i_data_valid = 1'b0;
      if (i == len + 4) bus_if.i_data_valid = 1'b1;
      if (i == len + 5) bus_if.i_data_valid = 1'b0;
    end
  endtask

  task automatic test_midframe_change();
    int len;
    len = 11 + STOP_X;
    // 0x3C has four ones: even parity bit 0
    bus_if.i_p_data     = 8'h3C;
    bus_if.i_par_en     = 1'b1;
    bus_if.i_par_typ    = 1'b0;
    bus_if.i_data_valid = 1'b1;
    for (int i = 0; i < len + 2; i++) begin
      @(negedge clk);
      bus_if.i_data_valid = 1'b0;
      checks++;
      if (bus_if.o_tx_out !== frame_bit(8'h3C, 1'b1, 1'b0, i)) begin
        errs++; $display("FAIL midchg_tx[%0d]: got %b want %b", i, bus_if.o_tx_out, frame_bit(8'h3C, 1'b1, 1'b0, i));
      end
      checks++;
      if (bus_if.o_busy !== (i < len)) begin
        errs++; $display("FAIL midchg_busy[%0d]: got %b want %b", i, bus_if.o_busy, (i < len));
      end
      if (i == 3) begin
        bus_if.i_p_data  = 8'hC3;
        bus_if.i_par_typ = 1'b1;
      end
    end
    bus_if.i_par_en  = 1'b0;
    bus_if.i_par_typ = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int len;
    len = 10 + STOP_X;
    bus_if.i_p_data     = 8'h55;
    bus_if.i_data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_if.i_data_valid = 1'b0;
      checks++;
      if (bus_if.o_tx_out !== frame_bit(8'h55, 1'b0, 1'b0, i)) begin
        errs++; $display("FAIL rstmid_pre_tx[%0d]: got %b want %b", i, bus_if.o_tx_out, frame_bit(8'h55, 1'b0, 1'b0, i));
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.o_tx_out !== 1'b1) begin
      errs++; $display("FAIL rstmid_tx: got %b want 1", bus_if.o_tx_out);
    end
    checks++;
    if (bus_if.o_busy !== 1'b0) begin
      errs++; $display("FAIL rstmid_busy: got %b want 0", bus_if.o_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.o_tx_out !== 1'b1 || bus_if.o_busy !== 1'b0) begin
      errs++; $display("FAIL rstmid_idle: got tx=%b busy=%b want tx=1 busy=0", bus_if.o_tx_out, bus_if.o_busy);
    end
    bus_if.i_data_valid = 1'b1;
    for (int i = 0; i < len + 2; i++) begin
      @(negedge clk);
      bus_if.i_data_valid = 1'b0;
      checks++;
      if (bus_if.o_tx_out !== frame_bit(8'h55, 1'b0, 1'b0, i)) begin
        errs++; $display("FAIL rstmid_post_tx[%0d]: got %b want %b", i, bus_if.o_tx_out, frame_bit(8'h55, 1'b0, 1'b0, i));
      end
      checks++;
      if (bus_if.o_busy !== (i < len)) begin
        errs++; $display("FAIL rstmid_post_busy[%0d]: got %b want %b", i, bus_if.o_busy, (i < len));
      end
    end
  endtask

`ifdef UART_TX_STOP2_EN
  task automatic test_stop2();
    // 0x81 LSB-first: 1,0,0,0,0,0,0,1 then stop bits at samples 9 and 10
    bus_if.i_p_data     = 8'h81;
    bus_if.i_par_en     = 1'b0;
    bus_if.i_data_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus_if.i_data_valid = 1'b0;
      checks++;
      if (bus_if.o_tx_out !== frame_bit(8'h81, 1'b0, 1'b0, i)) begin
        errs++; $display("FAIL stop2_tx[%0d]: got %b want %b", i, bus_if.o_tx_out, frame_bit(8'h81, 1'b0, 1'b0, i));
      end
      checks++;
      if (bus_if.o_busy !== (i < 11)) begin
        errs++; $display("FAIL stop2_busy[%0d]: got %b want %b", i, bus_if.o_busy, (i < 11));
      end
    end
  endtask
`endif

  initial begin
    bus_if.i_p_data     = 8'h00;
    bus_if.i_data_valid = 1'b0;
    bus_if.i_par_en     = 1'b0;
    bus_if.i_par_typ    = 1'b0;
    test_reset();
    test_basic();
    @(negedge clk);
    test_parity();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_midframe_change();
    @(negedge clk);
    test_reset_midframe();
`ifdef UART_TX_STOP2_EN
    @(negedge clk);
    test_stop2();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d of %0d checks", errs, checks);
    $fatal(1, "timeout");
  end
endmodule
